ervp_lpixm_sram_responder: RTL
==============================

ERVP_LPIXM_SRAM_RESPONDER -- requirements
Module: ERVP_LPIXM_SRAM_RESPONDER

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  BW_ADDR, 32, LPIXM address width.
  BW_DATA, 32, data width and SRAM word width (power of 2, at least 8).
  BW_AXI_TID, 1, id field width.
  MEM_DEPTH, 1024, SRAM words.
REQ-002 qdata SHALL be {id, write, len[8], size[3], burst[2], wstrb[BW_DATA/8], wdata, addr}, width BW_LPI_QDATA; ydata SHALL be {wreply, resp[2], rdata}, width BW_DATA+3.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  sole clock.
  reset  in  1  synchronous, active-high reset.
  smqdready  out  2  request ready; bit0 used, bit1 mirrors bit0.
  smqvalid  in  1  request beat valid.
  smqhint  in  1  ignored.
  smqlast  in  1  last write beat (1 for reads).
  smqafy  in  1  ignored.
  smqdata  in  BW_LPI_QDATA  request beat.
  smydready  in  2  response ready; bit0 used.
  smyvalid  out  1  response beat valid.
  smyhint  out  1  tied 0.
  smylast  out  1  last response beat.
  smydata  out  BW_DATA+3  response beat.
  mem_wenable  out  1  SRAM write.
  mem_waddr  out  LOG2RU(MEM_DEPTH)  write word index.
  mem_wstrb  out  BW_DATA/8  byte strobes.
  mem_wdata  out  BW_DATA  write data.
  mem_renable  out  1  SRAM read.
  mem_raddr  out  LOG2RU(MEM_DEPTH)  read word index.
  mem_rdata  in  BW_DATA  read data, valid 1 cycle after mem_renable.
  busy  out  1  high when state is not IDLE or the output buffer is non-empty.

Function
REQ-004 A q beat transfers when smqvalid & smqdready[0]; a y beat transfers when smyvalid & smydready[0].
REQ-005 FSM states SHALL be IDLE, WRITE, WRESP, READ.
REQ-006 IDLE: smqdready=2'b11; an accepted beat with write=1 performs the SRAM write in the same cycle; the next state is WRESP if smqlast, else WRITE.
REQ-007 IDLE: an accepted beat with write=0 latches addr, len, burst and id; the next state is READ with a remaining-beat count of len+1.
REQ-008 WRITE: smqdready=2'b11; each accepted beat writes the SRAM at the current address; the burst ends on smqlast regardless of len; smqlast moves the state to WRESP.
REQ-009 WRESP: smqdready=2'b00; one y beat {wreply=1, resp, rdata=0} with smylast=1 is presented; on acceptance the state returns to IDLE.
REQ-010 READ: smqdready=2'b00; mem_renable is issued once per beat, and only when (buffer occupancy + in-flight reads) < 2.
REQ-011 READ: data is captured into a 2-entry output FIFO on the cycle after each mem_renable; y beats are {0, resp, rdata}; smylast=1 on beat len+1; the state returns to IDLE when the last beat is issued, and busy stays high until the FIFO drains.
REQ-012 Address update: burst=FIXED SHALL hold the address; INCR and WRAP SHALL add BW_DATA/8 (WRAP is treated as INCR); size is ignored.
REQ-013 Word index SHALL be addr[LOG2RU(BW_DATA/8)+:LOG2RU(MEM_DEPTH)]; the address counter wraps modulo 2^BW_ADDR.
REQ-014 Read latency: a read request accepted in cycle T SHALL give first smyvalid in T+2 when smydready[0] is held 1; the block then sustains 1 beat per cycle.
REQ-015 With smydready[0]=0, the FIFO fills to 2 entries, issue stalls, and no data is lost or reordered.
REQ-016 resp SHALL be 2'b00 (OKAY) unless REQ-020 applies.

Reset
REQ-017 When reset=1 at a rising edge, the FSM goes to IDLE, the FIFO and in-flight counters clear, and any burst in progress is abandoned without a response.
REQ-018 During reset and in the cycle after it: smyvalid=0, mem_wenable=0, mem_renable=0, busy=0; smqdready=2'b00 while reset=1.

Configuration
REQ-019 Macro LPIXM_RESPONDER_RANGE_CHECK_EN SHALL control address range checking.
REQ-020 With LPIXM_RESPONDER_RANGE_CHECK_EN defined: a beat with word address >= MEM_DEPTH suppresses mem_wenable/mem_renable. A write reply then carries resp=2'b10 (SLVERR) if any beat of the burst was out of range. An out-of-range read beat returns rdata=0 with resp=2'b10.
REQ-021 With LPIXM_RESPONDER_RANGE_CHECK_EN undefined: the address is truncated per REQ-013 and resp is always 2'b00.

Verification
REQ-022 Single write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, last=1 -> mem_wenable at index 4; one reply with wreply=1, resp=0, smylast=1.
REQ-023 Read len=3 INCR addr=0x10 after a 4-beat write of 1..4 -> rdata 1,2,3,4, smylast only on beat 4, first smyvalid 2 cycles after acceptance.
REQ-024 Same read with smydready[0] toggling 1,0,0,1,... -> identical data sequence, at most 2 reads outstanding plus buffered.
REQ-025 FIXED read len=2 at 0x8 -> three beats, all equal to word 2.
REQ-026 Reset asserted mid write burst (beat 2 of 4) -> no reply, state IDLE, smqdready=2'b11 the cycle after reset deasserts.
REQ-027 With LPIXM_RESPONDER_RANGE_CHECK_EN and MEM_DEPTH=1024, write to 0x1000 -> no mem_wenable, reply resp=2'b10; without the macro -> write to index 0, resp=0.

Source files
------------

// File: rtl/ervp_lpixm_sram_responder.sv
// LPIXM slave that turns request/response beats into 1R1W SRAM accesses (macro LPIXM_RESPONDER_RANGE_CHECK_EN adds range errors).
// Latency: write reply 1 cycle after the last write beat; first read beat 2 cycles after request, then 1 beat/cycle.
// Backpressure: smydready low fills a 2-entry output buffer and stalls SRAM reads; requests only accepted in IDLE/WRITE.
module ervp_lpixm_sram_responder #(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int BW_AXI_TID = 1,
    parameter int MEM_DEPTH  = 1024,
    localparam int BW_STRB      = BW_DATA / 8,
    localparam int BW_MADDR     = $clog2(MEM_DEPTH),
    localparam int BW_LPI_QDATA = BW_AXI_TID + 1 + 8 + 3 + 2 + BW_STRB + BW_DATA + BW_ADDR
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [1:0]              smqdready,
    input  logic                    smqvalid,
    input  logic                    smqhint,
    input  logic                    smqlast,
    input  logic                    smqafy,
    input  logic [BW_LPI_QDATA-1:0] smqdata,
    input  logic [1:0]              smydready,
    output logic                    smyvalid,
    output logic                    smyhint,
    output logic                    smylast,
    output logic [BW_DATA+2:0]      smydata,
    output logic                    mem_wenable,
    output logic [BW_MADDR-1:0]     mem_waddr,
    output logic [BW_STRB-1:0]      mem_wstrb,
    output logic [BW_DATA-1:0]      mem_wdata,
    output logic                    mem_renable,
    output logic [BW_MADDR-1:0]     mem_raddr,
    input  logic [BW_DATA-1:0]      mem_rdata,
    output logic                    busy
);
    localparam int BYTE_SH = $clog2(BW_STRB);
    localparam int O_WDATA = BW_ADDR;
    localparam int O_WSTRB = O_WDATA + BW_DATA;
    localparam int O_BURST = O_WSTRB + BW_STRB;
    localparam int O_SIZE  = O_BURST + 2;
    localparam int O_LEN   = O_SIZE + 3;
    localparam int O_WRITE = O_LEN + 8;
    localparam int O_ID    = O_WRITE + 1;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

    typedef struct packed {
        logic               last;
        logic               err;
        logic [BW_DATA-1:0] dat;
    } rbeat_t;

    state_t state, state_nxt;

    logic [BW_ADDR-1:0]    q_addr;
    logic [BW_DATA-1:0]    q_wdata;
    logic [BW_STRB-1:0]    q_wstrb;
    logic [1:0]            q_burst;
    logic [2:0]            q_size;
    logic [7:0]            q_len;
    logic                  q_write;
    logic [BW_AXI_TID-1:0] q_id;

    assign q_addr  = smqdata[BW_ADDR-1:0];
    assign q_wdata = smqdata[O_WDATA +: BW_DATA];
    assign q_wstrb = smqdata[O_WSTRB +: BW_STRB];
    assign q_burst = smqdata[O_BURST +: 2];
    assign q_size  = smqdata[O_SIZE +: 3];
    assign q_len   = smqdata[O_LEN +: 8];
    assign q_write = smqdata[O_WRITE];
    assign q_id    = smqdata[O_ID +: BW_AXI_TID];

    logic [BW_ADDR-1:0]    addr_r;
    logic [1:0]            burst_r;
    logic [8:0]            rem_r;
    logic                  wr_err_r;
    logic [BW_AXI_TID-1:0] id_r;
    logic                  infl_r;
    logic                  infl_last_r;
    logic                  infl_err_r;
    rbeat_t                fifo_mem [2];
    logic                  fifo_wp;
    logic                  fifo_rp;
    logic [1:0]            fifo_cnt;

    logic [BW_ADDR-1:0] cur_addr;
    logic [1:0]         cur_burst;
    logic [BW_ADDR-1:0] nxt_addr;
    logic [BW_ADDR-1:0] cur_word;
    logic               cur_oob;

    // The first write beat and the read request carry the address on the bus; later beats use the counter.
    assign cur_addr  = (state == IDLE) ? q_addr : addr_r;
    assign cur_burst = (state == IDLE) ? q_burst : burst_r;
    assign nxt_addr  = (cur_burst == BURST_FIXED) ? cur_addr : cur_addr + BW_ADDR'(BW_STRB);
    assign cur_word  = cur_addr >> BYTE_SH;

`ifdef LPIXM_RESPONDER_RANGE_CHECK_EN
    assign cur_oob = (cur_word >= BW_ADDR'(MEM_DEPTH));
`else
    assign cur_oob = 1'b0;
`endif

    logic   q_rdy;
    logic   q_fire;
    logic   y_rdy;
    rbeat_t ret_beat;
    rbeat_t head;
    logic   rd_vld;
    logic   wr_vld;
    logic   rd_pop;
    logic   wr_pop;
    logic   fifo_push;
    logic   fifo_pop;
    logic   room;
    logic   wr_do;
    logic   rd_issue;

    assign q_rdy  = !reset && ((state == IDLE) || (state == WRITE));
    assign q_fire = smqvalid && q_rdy;
    assign y_rdy  = smydready[0];

    always_comb begin
        ret_beat      = '0;
        ret_beat.last = infl_last_r;
        ret_beat.err  = infl_err_r;
        ret_beat.dat  = infl_err_r ? '0 : mem_rdata;
    end

    // Returning SRAM data bypasses the buffer when it is empty, giving the 2-cycle read latency.
    assign head      = (fifo_cnt != 2'd0) ? fifo_mem[fifo_rp] : ret_beat;
    assign rd_vld    = (fifo_cnt != 2'd0) || infl_r;
    assign wr_vld    = (state == WRESP) && !rd_vld;
    assign rd_pop    = !reset && rd_vld && y_rdy;
    assign wr_pop    = !reset && wr_vld && y_rdy;
    assign fifo_push = infl_r && !((fifo_cnt == 2'd0) && rd_pop);
    assign fifo_pop  = rd_pop && (fifo_cnt != 2'd0);
    assign room      = (fifo_cnt + {1'b0, infl_r}) < 2'd2;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_do     = 1'b0;
        rd_issue  = 1'b0;
        unique case (state)
            IDLE: begin
                if (q_fire) begin
                    if (q_write) begin
                        wr_do     = 1'b1;
                        state_nxt = smqlast ? WRESP : WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            WRITE: begin
                if (q_fire) begin
                    wr_do = 1'b1;
                    if (smqlast) state_nxt = WRESP;
                end
            end
            WRESP: begin
                if (wr_pop) state_nxt = IDLE;
            end
            READ: begin
                if (room && !reset) begin
                    rd_issue = 1'b1;
                    if (rem_r == 9'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r      <= '0;
            burst_r     <= '0;
            rem_r       <= '0;
            wr_err_r    <= 1'b0;
            id_r        <= '0;
            infl_r      <= 1'b0;
            infl_last_r <= 1'b0;
            infl_err_r  <= 1'b0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (q_fire) begin
                if (state == IDLE) begin
                    burst_r  <= q_burst;
                    id_r     <= q_id;
                    wr_err_r <= cur_oob;
                    rem_r    <= {1'b0, q_len} + 9'd1;
                    addr_r   <= q_write ? nxt_addr : q_addr;
                end else begin
                    wr_err_r <= wr_err_r | cur_oob;
                    addr_r   <= nxt_addr;
                end
            end
            if (rd_issue) begin
                addr_r <= nxt_addr;
                rem_r  <= rem_r - 9'd1;
            end
            infl_r      <= rd_issue;
            infl_last_r <= rd_issue && (rem_r == 9'd1);
            infl_err_r  <= rd_issue && cur_oob;
            if (fifo_push) begin
                fifo_mem[fifo_wp] <= ret_beat;
                fifo_wp           <= ~fifo_wp;
            end
            if (fifo_pop) fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    assign smqdready   = {q_rdy, q_rdy};
    assign smyvalid    = !reset && (rd_vld || wr_vld);
    assign smyhint     = 1'b0;
    assign smylast     = rd_vld ? head.last : 1'b1;
    assign smydata     = rd_vld ? {1'b0, head.err, 1'b0, head.dat}
                                : {1'b1, wr_err_r, 1'b0, {BW_DATA{1'b0}}};
    assign mem_wenable = wr_do && !cur_oob;
    assign mem_waddr   = cur_word[BW_MADDR-1:0];
    assign mem_wstrb   = q_wstrb;
    assign mem_wdata   = q_wdata;
    assign mem_renable = rd_issue && !cur_oob;
    assign mem_raddr   = cur_word[BW_MADDR-1:0];
    assign busy        = !reset && ((state != IDLE) || rd_vld);

    logic unused_ok;
    assign unused_ok = ^{smqhint, smqafy, smydready[1], q_size, id_r, cur_word};

endmodule
